// File: rtl/ttt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ttt_pkg
// Description : Shared types and constants for the tic-tac-toe turn
//               controller: FSM state encoding, result codes, mark bit
//               offsets within a 2-bit cell, and the eight winning lines.
// Revision    : 1.0 - initial release
// ============================================================================
package ttt_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        CHECK = 3'd2,
        EVAL  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_X    = 2'b01;
    localparam logic [1:0] RES_O    = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    // Bit offset of each mark inside a cell's 2-bit field.
    localparam logic MARK_O = 1'b0;
    localparam logic MARK_X = 1'b1;

    // Cells (row-major 0..8) belonging to each winning line.
    localparam logic [3:0] LINE_CELLS [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

endpackage
`default_nettype wire

// File: rtl/ttt_turn_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : ttt_turn_controller_if
// Description : Game-side bundle of the turn controller.
//               Inputs to controller : game_en, key_data
//               Outputs from it      : board, turn_o, result, game_over, busy,
//                                      illegal, move_count, win_line
//               slave  = the controller, master = the surrounding system.
// Revision    : 1.0 - initial release
// ============================================================================
interface ttt_turn_controller_if;
    logic        game_en;
    logic [3:0]  key_data;
    logic [17:0] board;
    logic        turn_o;
    logic [1:0]  result;
    logic        game_over;
    logic        busy;
    logic        illegal;
    logic [3:0]  move_count;
    logic [7:0]  win_line;

    modport master (
        output game_en, key_data,
        input  board, turn_o, result, game_over, busy, illegal, move_count, win_line
    );

    modport slave (
        input  game_en, key_data,
        output board, turn_o, result, game_over, busy, illegal, move_count, win_line
    );
endinterface
`default_nettype wire

// File: rtl/ttt_line_checker.sv
`default_nettype none
// ============================================================================
// Module      : ttt_line_checker
// Description : Combinational test of one winning line for three marks of
//               the moving player.
//   board_i    [17:0] board, cell k at [2k+1:2k] (bit 2k O, bit 2k+1 X)
//   line_idx_i [2:0]  line to test (index into LINE_CELLS)
//   mover_i           1 = O, 0 = X
//   hit_o             all three cells of the line hold the mover's mark
// Revision    : 1.0 - initial release
// ============================================================================
module ttt_line_checker
    import ttt_pkg::*;
(
    input  logic [17:0] board_i,
    input  logic [2:0]  line_idx_i,
    input  logic        mover_i,
    output logic        hit_o
);
    logic mark;

    always_comb begin
        mark  = mover_i ? MARK_O : MARK_X;
        hit_o = 1'b1;
        for (int j = 0; j < 3; j++) begin
            // {cell, mark} is the bit position 2*cell + mark.
            hit_o = hit_o & board_i[{LINE_CELLS[line_idx_i][j], mark}];
        end
    end
endmodule
`default_nettype wire

// File: rtl/ttt_turn_controller.sv
`default_nettype none
// ============================================================================
// Module      : ttt_turn_controller
// Description : Tic-tac-toe move sequencer. Validates keypad moves, writes
//               X/O marks, scans the eight lines one per cycle after each
//               move and reports win/draw.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of ttt_turn_controller_if (key input, board,
//                turn, result and status outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module ttt_turn_controller
    import ttt_pkg::*;
#(
    parameter logic [3:0] KEY_RESTART = 4'hF,
    parameter bit         FIRST_O     = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ttt_turn_controller_if.slave bus
);
    state_t      state_q;
    logic [17:0] board_q;
    logic        turn_q;
    logic [1:0]  result_q;
    logic        game_over_q;
    logic        busy_q;
    logic        illegal_q;
    logic [3:0]  count_q;
    logic [7:0]  win_q;
    logic [3:0]  key_prev_q;
    logic [3:0]  cell_q;
    logic [2:0]  idx_q;

    logic press_evt;
    logic restart_evt;
    logic move_key;
    logic occupied;
    logic mark;
    logic hit;

    assign press_evt   = (bus.key_data != 4'd0) && (key_prev_q == 4'd0);
    assign restart_evt = press_evt && (bus.key_data == KEY_RESTART) && (state_q != IDLE);
    assign move_key    = (bus.key_data >= 4'd1) && (bus.key_data <= 4'd9);
    assign occupied    = board_q[{cell_q, 1'b0}] | board_q[{cell_q, 1'b1}];
    assign mark        = turn_q ? MARK_O : MARK_X;

    ttt_line_checker u_line_checker (
        .board_i    (board_q),
        .line_idx_i (idx_q),
        .mover_i    (turn_q),
        .hit_o      (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            board_q     <= 18'd0;
            turn_q      <= FIRST_O;
            result_q    <= RES_NONE;
            game_over_q <= 1'b0;
            busy_q      <= 1'b0;
            illegal_q   <= 1'b0;
            count_q     <= 4'd0;
            win_q       <= 8'd0;
            key_prev_q  <= 4'd0;
            cell_q      <= 4'd0;
            idx_q       <= 3'd0;
        end else begin
            key_prev_q <= bus.key_data;
            illegal_q  <= 1'b0;

            // Restart outranks every state action, including a running scan.
            if (restart_evt) begin
                state_q     <= WAIT;
                board_q     <= 18'd0;
                turn_q      <= FIRST_O;
                result_q    <= RES_NONE;
                game_over_q <= 1'b0;
                busy_q      <= 1'b0;
                count_q     <= 4'd0;
                win_q       <= 8'd0;
                idx_q       <= 3'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.game_en) begin
                            state_q <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (!bus.game_en) begin
                            state_q <= IDLE;
                        end else if (press_evt && move_key) begin
                            cell_q  <= bus.key_data - 4'd1;
                            busy_q  <= 1'b1;
                            state_q <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (occupied) begin
                            illegal_q <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= WAIT;
                        end else begin
                            board_q[{cell_q, mark}] <= 1'b1;
                            count_q <= count_q + 4'd1;
                            idx_q   <= 3'd0;
                            state_q <= EVAL;
                        end
                    end
                    EVAL: begin
                        if (hit) begin
                            win_q[idx_q] <= 1'b1;
                        end
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            busy_q <= 1'b0;
                            // The hit of the last line is not in win_q yet.
                            if ((win_q != 8'd0) || hit) begin
                                result_q    <= turn_q ? RES_O : RES_X;
                                game_over_q <= 1'b1;
                                state_q     <= DONE;
                            end else if (count_q == 4'd9) begin
                                result_q    <= RES_DRAW;
                                game_over_q <= 1'b1;
                                state_q     <= DONE;
                            end else begin
                                turn_q  <= ~turn_q;
                                state_q <= WAIT;
                            end
                        end
                    end
                    DONE: begin
                        state_q <= DONE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.board      = board_q;
    assign bus.turn_o     = turn_q;
    assign bus.result     = result_q;
    assign bus.game_over  = game_over_q;
    assign bus.busy       = busy_q;
    assign bus.illegal    = illegal_q;
    assign bus.move_count = count_q;
    assign bus.win_line   = win_q;

endmodule
`default_nettype wire

// File: tb/tb_ttt_turn_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ttt_turn_controller
// Description : Self-checking bench for ttt_turn_controller. A game-level
//               model (cell array, whole-board win search at move time,
//               visibility delayed to the documented latencies) is compared
//               against the outputs every cycle, plus literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ttt_turn_controller;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    ttt_turn_controller_if bus ();

    ttt_turn_controller #(
        .KEY_RESTART (4'hF),
        .FIRST_O     (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- game-level model ----------------
    localparam int M_IDLE = 0, M_WAIT = 1, M_BUSY = 2, M_DONE = 3;

    int         lt [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                             '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int         m_cell [9];      // 0 empty, 1 X, 2 O
    int         m_mode;
    int         m_step;
    int         m_prev;
    int         m_pick;
    int         m_count;
    bit         m_turn;
    bit         m_over;
    bit         m_busy;
    bit         m_illegal;
    logic [1:0] m_result;
    logic [7:0] m_win;
    logic [7:0] p_win;

    function automatic logic [17:0] m_board();
        logic [17:0] b;
        b = '0;
        for (int k = 0; k < 9; k++) begin
            if (m_cell[k] == 1) b[2*k+1] = 1'b1;
            if (m_cell[k] == 2) b[2*k]   = 1'b1;
        end
        return b;
    endfunction

    task automatic m_clear_game();
        for (int k = 0; k < 9; k++) m_cell[k] = 0;
        m_count = 0; m_turn = 1'b0; m_over = 1'b0; m_busy = 1'b0;
        m_result = 2'b00; m_win = 8'h00; p_win = 8'h00; m_step = 0;
    endtask

    task automatic model_step();
        int  k;
        bit  press;
        int  mv;
        if (!rst_n) begin
            m_clear_game();
            m_prev = 0; m_illegal = 1'b0; m_mode = M_IDLE; m_pick = 0;
            return;
        end
        k = int'(bus.key_data);
        press = (k != 0) && (m_prev == 0);
        m_prev = k;
        m_illegal = 1'b0;
        if (press && k == 15 && m_mode != M_IDLE) begin
            m_clear_game();
            m_mode = M_WAIT;
            return;
        end
        case (m_mode)
            M_IDLE: if (bus.game_en) m_mode = M_WAIT;
            M_WAIT: begin
                if (!bus.game_en) m_mode = M_IDLE;
                else if (press && k >= 1 && k <= 9) begin
                    m_pick = k - 1; m_mode = M_BUSY; m_busy = 1'b1; m_step = 0;
                end
            end
            M_BUSY: begin
                m_step++;
                mv = m_turn ? 2 : 1;
                if (m_step == 1) begin
                    if (m_cell[m_pick] != 0) begin
                        m_illegal = 1'b1; m_busy = 1'b0; m_mode = M_WAIT;
                    end else begin
                        m_cell[m_pick] = mv;
                        m_count++;
                        p_win = 8'h00;
                        for (int i = 0; i < 8; i++)
                            if (m_cell[lt[i][0]] == mv && m_cell[lt[i][1]] == mv &&
                                m_cell[lt[i][2]] == mv) p_win[i] = 1'b1;
                    end
                end else begin
                    // Line (step-2) becomes visible after this edge.
                    m_win[m_step-2] = p_win[m_step-2];
                    if (m_step == 9) begin
                        m_busy = 1'b0;
                        if (p_win != 8'h00) begin
                            m_result = m_turn ? 2'b10 : 2'b01; m_over = 1'b1; m_mode = M_DONE;
                        end else if (m_count == 9) begin
                            m_result = 2'b11; m_over = 1'b1; m_mode = M_DONE;
                        end else begin
                            m_turn = ~m_turn; m_mode = M_WAIT;
                        end
                    end
                end
            end
            default: ;
        endcase
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        chk("board",      32'(bus.board),      32'(m_board()));
        chk("turn_o",     32'(bus.turn_o),     32'(m_turn));
        chk("result",     32'(bus.result),     32'(m_result));
        chk("game_over",  32'(bus.game_over),  32'(m_over));
        chk("busy",       32'(bus.busy),       32'(m_busy));
        chk("illegal",    32'(bus.illegal),    32'(m_illegal));
        chk("move_count", 32'(bus.move_count), 32'(m_count));
        chk("win_line",   32'(bus.win_line),   32'(m_win));
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_move(input int k);
        bus.key_data = 4'(k);
        tick(1);
        bus.key_data = 4'd0;
        tick(11);
    endtask

    task automatic do_restart();
        bus.key_data = 4'hF;
        tick(1);
        bus.key_data = 4'd0;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.game_en  = 1'b1;
        bus.key_data = 4'd0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_board", 32'(bus.board), 32'h0);
        chk("rst_turn",  32'(bus.turn_o), 32'h0);
        chk("rst_count", 32'(bus.move_count), 32'h0);
        chk("rst_busy",  32'(bus.busy), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // First move: X at cell 4.
        bus.key_data = 4'd5;
        tick(1);
        chk("t1_busy_e0", 32'(bus.busy), 32'h1);
        bus.key_data = 4'd0;
        tick(1);
        chk("t1_board_e1", 32'(bus.board), 32'h00200);
        tick(8);
        chk("t1_turn_e9",  32'(bus.turn_o), 32'h1);
        chk("t1_count_e9", 32'(bus.move_count), 32'h1);
        chk("t1_busy_e9",  32'(bus.busy), 32'h0);
        tick(2);

        // Same cell again: illegal for one cycle only.
        bus.key_data = 4'd5;
        tick(1);
        bus.key_data = 4'd0;
        tick(1);
        chk("t2_illegal_hi", 32'(bus.illegal), 32'h1);
        tick(1);
        chk("t2_illegal_lo", 32'(bus.illegal), 32'h0);
        chk("t2_board", 32'(bus.board), 32'h00200);
        chk("t2_turn",  32'(bus.turn_o), 32'h1);
        chk("t2_count", 32'(bus.move_count), 32'h1);
        tick(2);
        do_restart();

        // X wins on row 0.
        do_move(1); do_move(4); do_move(2); do_move(5); do_move(3);
        chk("t3_result", 32'(bus.result), 32'h1);
        chk("t3_win",    32'(bus.win_line), 32'h01);
        chk("t3_over",   32'(bus.game_over), 32'h1);
        do_move(9);
        chk("t3_board_hold", 32'(bus.board), 32'h0016A);
        bus.game_en = 1'b0;
        tick(3);
        chk("t3_over_hold", 32'(bus.game_over), 32'h1);
        bus.game_en = 1'b1;
        do_restart();

        // Draw.
        do_move(1); do_move(2); do_move(3); do_move(5); do_move(4);
        do_move(6); do_move(8); do_move(7); do_move(9);
        chk("t4_result", 32'(bus.result), 32'h3);
        chk("t4_count",  32'(bus.move_count), 32'h9);
        chk("t4_win",    32'(bus.win_line), 32'h00);
        do_restart();

        // Ninth move completes row 0 and column 0.
        do_move(2); do_move(5); do_move(3); do_move(6); do_move(4);
        do_move(8); do_move(7); do_move(9); do_move(1);
        chk("t5_win",    32'(bus.win_line), 32'h09);
        chk("t5_result", 32'(bus.result), 32'h1);
        do_restart();

        // Restart mid-scan while key 1 is held across it.
        bus.key_data = 4'd3;
        tick(1);
        bus.key_data = 4'd0;
        tick(1);
        tick(3);
        bus.key_data = 4'hF;
        tick(1);
        chk("t6_board", 32'(bus.board), 32'h0);
        chk("t6_turn",  32'(bus.turn_o), 32'h0);
        chk("t6_count", 32'(bus.move_count), 32'h0);
        chk("t6_busy",  32'(bus.busy), 32'h0);
        bus.key_data = 4'd1;
        tick(3);
        chk("t6_held_nomove", 32'(bus.board), 32'h0);
        bus.key_data = 4'd0;
        tick(1);
        bus.key_data = 4'd1;
        tick(1);
        bus.key_data = 4'd0;
        tick(11);
        chk("t6_repress", 32'(bus.board), 32'h00002);
        chk("t6_turn2",   32'(bus.turn_o), 32'h1);

        // Keys ignored in IDLE; board kept across IDLE.
        bus.game_en = 1'b0;
        tick(2);
        bus.key_data = 4'd2;
        tick(1);
        bus.key_data = 4'd0;
        tick(3);
        chk("t7_idle_board", 32'(bus.board), 32'h00002);
        chk("t7_idle_busy",  32'(bus.busy), 32'h0);
        bus.game_en = 1'b1;
        tick(2);
        do_move(2);
        chk("t7_o_move", 32'(bus.board), 32'h00006);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
